fifo_arb: RTL and testbench

FIFO_ARB -- requirements
Module: fifo_arb

---
 rtl/fifo_arb_if.sv | 28 ++
 rtl/fifo_arb.sv | 129 ++++++++++++
 tb/tb_fifo_arb.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_arb_if.sv
// Bundle of the requester-side and FIFO-side signals of fifo_arb.
// slave: the arbiter's view. master: the view of whatever drives the requesters and FIFO.
interface fifo_arb_if #(
  parameter int N_REQ   = 4,
  parameter int D_WIDTH = 32
);
  localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]         req_i;
  logic [N_REQ*D_WIDTH-1:0] data_i;
  logic [N_REQ-1:0]         last_i;
  logic [N_REQ-1:0]         gnt_o;
  logic                     fifo_wr_en_o;
  logic [D_WIDTH-1:0]       fifo_din_o;
  logic                     fifo_full_i;
  logic                     busy_o;
  logic [OW-1:0]            owner_o;

  modport slave (
    input  req_i, data_i, last_i, fifo_full_i,
    output gnt_o, fifo_wr_en_o, fifo_din_o, busy_o, owner_o
  );

  modport master (
    output req_i, data_i, last_i, fifo_full_i,
    input  gnt_o, fifo_wr_en_o, fifo_din_o, busy_o, owner_o
  );
endinterface

// File: rtl/fifo_arb.sv
// Round-robin burst arbiter: N_REQ requesters share one FIFO write port.
// An owner is picked in IDLE (one bubble cycle). It then streams beats in BURST
// until it sends last, hits MAX_BURST beats or drops its request.
//
// state | meaning
// IDLE  | no owner active; arbitrate from rr_ptr, no beats
// BURST | owner holds the FIFO; a beat occurs when it requests and the FIFO is not full
module fifo_arb #(
  parameter int N_REQ     = 4,
  parameter int D_WIDTH   = 32,
  parameter int MAX_BURST = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  fifo_arb_if.slave  bus
);

  localparam int         OW      = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [7:0] MAX_CNT = 8'(MAX_BURST);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [OW-1:0]      owner_q, owner_d;
  logic [OW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [7:0]         cnt_q, cnt_d;

  logic [OW-1:0]      pick;
  logic               pick_vld;
  logic               own_req;
  logic               own_last;
  logic [D_WIDTH-1:0] own_data;
  logic               beat;

  logic [N_REQ-1:0]   gnt;
  logic               wr_en;
  logic [D_WIDTH-1:0] din;
  logic               busy;

  // (base + off) mod N_REQ without a divider; off is always below N_REQ
  function automatic logic [OW-1:0] wrap_idx(input logic [OW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N_REQ) s = s - N_REQ;
    return OW'(s);
  endfunction

  // Round-robin pick: scanned from the far end so the port closest to rr_ptr wins
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (bus.req_i[wrap_idx(rr_ptr_q, i)]) begin
        pick     = wrap_idx(rr_ptr_q, i);
        pick_vld = 1'b1;
      end
    end
  end

  // Current owner's request, last flag and data lane
  always_comb begin
    own_req  = bus.req_i[owner_q];
    own_last = bus.last_i[owner_q];
    own_data = bus.data_i[int'(owner_q)*D_WIDTH +: D_WIDTH];
  end

  // Next-state and output decode
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    beat     = 1'b0;
    gnt      = '0;
    wr_en    = 1'b0;
    din      = '0;
    busy     = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          owner_d = pick;
          cnt_d   = 8'd0;
          state_d = BURST;
        end
      end
      BURST: begin
        busy = 1'b1;
        din  = own_data;
        beat = own_req & ~bus.fifo_full_i;
        if (beat) begin
          gnt[owner_q] = 1'b1;
          wr_en        = 1'b1;
          if (cnt_q < MAX_CNT) cnt_d = cnt_q + 8'd1;
        end
        // A withdrawn owner ends the burst even while the FIFO is full
        if (!own_req || (beat && (own_last || cnt_d == MAX_CNT))) begin
          state_d  = IDLE;
          rr_ptr_d = wrap_idx(owner_q, 1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, owner, pointer and beat counter registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      cnt_q    <= 8'd0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.gnt_o        = gnt;
  assign bus.fifo_wr_en_o = wr_en;
  assign bus.fifo_din_o   = din;
  assign bus.busy_o       = busy;
  assign bus.owner_o      = owner_q;

endmodule

// File: tb/tb_fifo_arb.sv
// Bench for fifo_arb: directed scenarios, a transaction-level model compared every cycle,
// and literal grant traces per scenario.
module tb_fifo_arb;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int MB = 4;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  fifo_arb_if #(.N_REQ(N), .D_WIDTH(DW)) bus ();

  fifo_arb #(.N_REQ(N), .D_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // producers: each port offers beats_left beats; data word = {port, sequence number}
  int beats_left[N];
  bit last_en[N];
  int seq[N];
  bit full;

  logic [3:0] trace[$];

  // model: who owns the FIFO, beats sent in this grant, next start point, per-port words sent
  bit m_busy  = 1'b0;
  int m_owner = 0;
  int m_cnt   = 0;
  int m_ptr   = 0;
  int m_sent[N];

  function automatic logic [DW-1:0] word(input int k, input int s);
    return {16'(k), 16'(s)};
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      bus.req_i[k]             = (beats_left[k] > 0);
      bus.last_i[k]            = last_en[k] && (beats_left[k] == 1);
      bus.data_i[k*DW +: DW]   = word(k, seq[k]);
    end
    bus.fifo_full_i = full;
  endtask

  task automatic step();
    logic [N-1:0] g;
    @(negedge clk_i);
    g = bus.gnt_o;
    @(posedge clk_i);
    #1;
    for (int k = 0; k < N; k++) begin
      if (g[k] && beats_left[k] > 0) begin
        beats_left[k]--;
        seq[k]++;
      end
    end
    drive();
  endtask

  task automatic go();
    drive();
    trace.delete();
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    for (int k = 0; k < N; k++) begin
      beats_left[k] = 0;
      last_en[k]    = 1'b0;
    end
    full = 1'b0;
    drive();
    step();
    step();
    rst_i = 1'b0;
    drive();
  endtask

  task automatic check_trace(input string name, input string exp);
    string got;
    bit    bad;
    got = "";
    bad = (trace.size() < exp.len());
    for (int i = 0; i < exp.len() && i < trace.size(); i++) begin
      got = {got, $sformatf("%0h", trace[i])};
      if (trace[i] !== 4'(exp[i] - 8'd48)) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL trace_%s got=%s exp=%s", name, got, exp);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_gnt"},   64'(bus.gnt_o),        64'd0);
    chk({tag, "_wr"},    64'(bus.fifo_wr_en_o), 64'd0);
    chk({tag, "_din"},   64'(bus.fifo_din_o),   64'd0);
    chk({tag, "_busy"},  64'(bus.busy_o),       64'd0);
    chk({tag, "_owner"}, 64'(bus.owner_o),      64'd0);
  endtask

  // per-cycle compare against the model, then advance the model across the coming edge
  always @(negedge clk_i) begin
    logic [N-1:0]  eg;
    logic          ewr;
    logic [DW-1:0] edin;
    logic          eb;
    int            eo;
    bit            beat;
    bit            found;
    int            k;
    trace.push_back(bus.gnt_o);
    eg   = '0;
    ewr  = 1'b0;
    edin = '0;
    eb   = 1'b0;
    eo   = m_owner;
    if (rst_i) begin
      eo      = 0;
      m_busy  = 1'b0;
      m_owner = 0;
      m_cnt   = 0;
      m_ptr   = 0;
    end else if (!m_busy) begin
      if (bus.req_i != '0) begin
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
          k = (m_ptr + i) % N;
          if (!found && bus.req_i[k]) begin
            m_owner = k;
            found   = 1'b1;
          end
        end
        m_busy = 1'b1;
        m_cnt  = 0;
      end
    end else begin
      eb   = 1'b1;
      edin = word(m_owner, m_sent[m_owner]);
      beat = bus.req_i[m_owner] && !bus.fifo_full_i;
      ewr  = beat;
      if (beat) begin
        eg[m_owner] = 1'b1;
        m_sent[m_owner]++;
        m_cnt++;
      end
      if (!bus.req_i[m_owner] || (beat && (bus.last_i[m_owner] || m_cnt == MB))) begin
        m_busy = 1'b0;
        m_ptr  = (m_owner + 1) % N;
      end
    end
    chk("gnt",   64'(bus.gnt_o),        64'(eg));
    chk("wr_en", 64'(bus.fifo_wr_en_o), 64'(ewr));
    chk("din",   64'(bus.fifo_din_o),   64'(edin));
    chk("busy",  64'(bus.busy_o),       64'(eb));
    chk("owner", 64'(bus.owner_o),      64'(eo));
  end

  initial begin
    full = 1'b0;
    for (int k = 0; k < N; k++) begin
      beats_left[k] = 0;
      last_en[k]    = 1'b0;
      seq[k]        = 0;
      m_sent[k]     = 0;
    end
    rst_i = 1'b1;
    drive();
    repeat (3) @(posedge clk_i);
    #1;
    check_zero_outputs("reset");
    rst_i = 1'b0;
    drive();
    step();

    // single requester, 3 beats with last on the third
    beats_left[0] = 3;
    last_en[0]    = 1'b1;
    go();
    repeat (5) step();
    check_trace("single", "01110");
    repeat (2) step();

    // all four requesting, no last: MAX_BURST-limited bursts in rotation
    do_reset();
    for (int k = 0; k < N; k++) beats_left[k] = 100;
    go();
    repeat (25) step();
    check_trace("round_robin", "0111102222044440888801111");
    for (int k = 0; k < N; k++) beats_left[k] = 0;
    drive();
    repeat (3) step();

    // FIFO full for 5 cycles after two beats of port 1
    do_reset();
    beats_left[1] = 10;
    go();
    repeat (3) step();
    full = 1'b1;
    drive();
    repeat (5) step();
    full = 1'b0;
    drive();
    repeat (3) step();
    check_trace("backpressure", "02200000220");
    beats_left[1] = 0;
    drive();
    repeat (3) step();

    // owner 2 withdraws after one beat while port 3 waits
    do_reset();
    beats_left[2] = 1;
    beats_left[3] = 2;
    last_en[3]    = 1'b1;
    go();
    repeat (7) step();
    check_trace("withdraw", "0400880");

    // pointer at 3 after port 2's burst, then req 0101 must wrap to port 0
    do_reset();
    beats_left[2] = 1;
    last_en[2]    = 1'b1;
    go();
    repeat (3) step();
    beats_left[0] = 1;
    last_en[0]    = 1'b1;
    beats_left[2] = 1;
    drive();
    repeat (5) step();
    check_trace("wrap", "04001040");

    // reset after two beats of port 1, then restart from port 0
    do_reset();
    beats_left[1] = 10;
    go();
    repeat (3) step();
    rst_i = 1'b1;
    #1;
    check_zero_outputs("mid_reset");
    repeat (2) step();
    check_trace("pre_reset", "02200");
    beats_left[0] = 2;
    beats_left[1] = 2;
    last_en[0]    = 1'b1;
    last_en[1]    = 1'b1;
    rst_i = 1'b0;
    go();
    repeat (7) step();
    check_trace("post_reset", "0110220");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
